// File: rtl/norm_mult_if.sv
// Sample/gain/result bundle for the gain-normalisation multiplier.
// The source drives din and coef and the multiplier returns dout.
interface norm_mult_if;
  logic [15:0] din;
  logic [15:0] coef;
  logic [15:0] dout;

  modport master (
    output din,
    output coef,
    input  dout
  );

  modport slave (
    input  din,
    input  coef,
    output dout
  );
endinterface

// File: rtl/norm_mult.sv
// Three-stage signed x unsigned 1.15 gain multiplier with round-half-up and 16-bit saturation.
// Free-running pipeline with no stalls; latency is three clock edges.
module norm_mult (
  input logic         clk,
  input logic         arst,
  norm_mult_if.slave  bus
);

  logic [15:0]        din_q;
  logic [15:0]        coef_q;
  logic signed [32:0] prod_d;
  logic signed [32:0] prod_q;
  logic signed [32:0] rnd;
  logic signed [17:0] shifted;
  logic [15:0]        dout_d;
  logic [15:0]        dout_q;

  // coef is zero-extended so 0x8000..0xFFFF stay positive gains.
  always_comb begin
    prod_d = $signed({{17{din_q[15]}}, din_q}) * $signed({17'd0, coef_q});
  end

  always_comb begin
    rnd     = prod_q + 33'sd16384;
    shifted = $signed(rnd[32:15]);
    if (shifted > 18'sd32767) begin
      dout_d = 16'h7FFF;
    end else if (shifted < -18'sd32768) begin
      dout_d = 16'h8000;
    end else begin
      dout_d = shifted[15:0];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      din_q  <= '0;
      coef_q <= '0;
      prod_q <= '0;
      dout_q <= '0;
    end else begin
      din_q  <= bus.din;
      coef_q <= bus.coef;
      prod_q <= prod_d;
      dout_q <= dout_d;
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_norm_mult.sv
// Scoreboard bench for norm_mult: expectations are queued as stimulus is applied and
// popped three edges later when the matching result is on dout.
module tb_norm_mult;

  typedef struct {
    logic [15:0] v;
    string       n;
  } exp_t;

  logic clk;
  logic arst;
  int   checks;
  int   errors;
  exp_t sb[$];

  norm_mult_if bus ();

  norm_mult dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model of the arithmetic, used for the mixed-value sweep.
  function automatic logic [15:0] model(input logic [15:0] d, input logic [15:0] c);
    longint p;
    longint r;
    p = longint'($signed(d)) * longint'({16'd0, c});
    r = (p + 64'sd16384) >>> 15;
    if (r > 32767) return 16'h7FFF;
    if (r < -32768) return 16'h8000;
    return r[15:0];
  endfunction

  // Applies one sample for the next edge, queues its expectation, returns at edge + 1.
  task automatic drive(input logic [15:0] d, input logic [15:0] c, input logic [15:0] e,
                       input string n);
    exp_t ent;
    bus.din  = d;
    bus.coef = c;
    ent.v = e;
    ent.n = n;
    sb.push_back(ent);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_t z;
    z.v = 16'h0000;
    z.n = "post_reset_zero";
    sb = {};
    sb.push_back(z);
    sb.push_back(z);
  endtask

  task automatic test_reset();
    exp_t ent;
    arst     = 1'b1;
    bus.din  = 16'h7FFF;
    bus.coef = 16'hFFFF;
    #12;
    checks++;
    if (bus.dout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_hold: dout=%0d required 0", $signed(bus.dout));
    end
    #1;
    arst = 1'b0;
    clear_sb();
    for (int i = 0; i < 4; i++) begin
      drive(16'(i + 5), 16'h8000, 16'(i + 5), "reset_first");
      if (sb.size() == 3) begin
        ent = sb.pop_front();
        checks++;
        if (bus.dout !== ent.v) begin
          errors++;
          $display("FAIL %s: dout=%0d required %0d", ent.n, $signed(bus.dout), $signed(ent.v));
        end
      end
    end
  endtask

  task automatic test_unity();
    exp_t        ent;
    logic [15:0] d;
    d = 16'h0000;
    for (int i = 0; i < 24; i++) begin
      drive(d, 16'h8000, d, "unity");
      if (sb.size() == 3) begin
        ent = sb.pop_front();
        checks++;
        if (bus.dout !== ent.v) begin
          errors++;
          $display("FAIL %s: dout=%0d required %0d", ent.n, $signed(bus.dout), $signed(ent.v));
        end
      end
      d = 16'h0000 - (d << 1) + 16'h0001;
    end
  endtask

  task automatic test_gain_table();
    exp_t        ent;
    logic [15:0] dv[0:13];
    logic [15:0] cv[0:13];
    logic [15:0] ev[0:13];
    dv = '{16'd3, 16'(-3), 16'd1, 16'(-1), 16'd100,
           16'd100, 16'd30000, 16'(-30000),
           16'd32767, 16'h8000, 16'd1,
           16'd12345, 16'h8000, 16'd32767};
    cv = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000,
           16'hC000, 16'hC000, 16'hC000,
           16'hFFFF, 16'hFFFF, 16'hFFFF,
           16'h0000, 16'h0000, 16'h0000};
    ev = '{16'd2, 16'(-1), 16'd1, 16'd0, 16'd50,
           16'd150, 16'd32767, 16'h8000,
           16'd32767, 16'h8000, 16'd2,
           16'd0, 16'd0, 16'd0};
    for (int i = 0; i < 14; i++) begin
      drive(dv[i], cv[i], ev[i], "gain_table");
      if (sb.size() == 3) begin
        ent = sb.pop_front();
        checks++;
        if (bus.dout !== ent.v) begin
          errors++;
          $display("FAIL %s: dout=%0d required %0d", ent.n, $signed(bus.dout), $signed(ent.v));
        end
      end
    end
  endtask

  task automatic test_coef_switch();
    exp_t ent;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) drive(16'd1000, 16'h8000, 16'd1000, "coef_switch");
      else            drive(16'd1000, 16'h4000, 16'd500, "coef_switch");
      if (sb.size() == 3) begin
        ent = sb.pop_front();
        checks++;
        if (bus.dout !== ent.v) begin
          errors++;
          $display("FAIL %s: dout=%0d required %0d", ent.n, $signed(bus.dout), $signed(ent.v));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        ent;
    logic [15:0] d;
    logic [15:0] c;
    for (int i = 0; i < 30; i++) begin
      d = 16'($urandom);
      c = 16'($urandom);
      if (i % 5 == 0) d = 16'h8000;
      if (i % 7 == 0) c = 16'hFFFF;
      drive(d, c, model(d, c), "random");
      if (sb.size() == 3) begin
        ent = sb.pop_front();
        checks++;
        if (bus.dout !== ent.v) begin
          errors++;
          $display("FAIL %s: dout=%0d required %0d", ent.n, $signed(bus.dout), $signed(ent.v));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t ent;
    for (int i = 0; i < 5; i++) begin
      drive(16'd1234, 16'h8000, 16'd1234, "pre_reset");
      if (sb.size() == 3) begin
        ent = sb.pop_front();
        checks++;
        if (bus.dout !== ent.v) begin
          errors++;
          $display("FAIL %s: dout=%0d required %0d", ent.n, $signed(bus.dout), $signed(ent.v));
        end
      end
    end
    // Pulse between edges with three 1234 samples still in flight.
    #1;
    arst     = 1'b1;
    bus.din  = 16'd4321;
    bus.coef = 16'hFFFF;
    #1;
    checks++;
    if (bus.dout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async: dout=%0d required 0", $signed(bus.dout));
    end
    #1;
    arst = 1'b0;
    clear_sb();
    for (int i = 0; i < 6; i++) begin
      drive(16'd77, 16'h8000, 16'd77, "post_reset");
      if (sb.size() == 3) begin
        ent = sb.pop_front();
        checks++;
        if (bus.dout !== ent.v) begin
          errors++;
          $display("FAIL %s: dout=%0d required %0d", ent.n, $signed(bus.dout), $signed(ent.v));
        end
      end
    end
  endtask

  task automatic drain();
    exp_t ent;
    for (int i = 0; i < 3; i++) begin
      drive(16'd9, 16'h0000, 16'd0, "drain");
      if (sb.size() == 3) begin
        ent = sb.pop_front();
        checks++;
        if (bus.dout !== ent.v) begin
          errors++;
          $display("FAIL %s: dout=%0d required %0d", ent.n, $signed(bus.dout), $signed(ent.v));
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unity();
    test_gain_table();
    test_coef_switch();
    test_back_to_back();
    test_reset_midstream();
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
